// File: rtl/seven_tube_capture.sv
// Reader side of a six-digit multiplexed seven-segment scan bus: debounces each digit,
// decodes it back to a hex nibble and reassembles the 24-bit word shown on the display.
module seven_tube_capture #(
    parameter int unsigned SETTLE = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_in,
    input  logic [2:0]  sel_in,
    output logic [23:0] odata,
    output logic        odata_valid,
    output logic        frame_err
);

    typedef enum logic {WAIT, COLLECT} state_t;

    localparam logic [15:0] SETTLE_W  = 16'(SETTLE);
    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE - 1);

    logic [2:0]  sel_m, s_sel, p_sel, last_sel, exp_idx, exp_d;
    logic [7:0]  seg_m, s_seg, p_seg;
    logic [15:0] cnt;
    logic [23:0] dbuf, dbuf_d, odata_d;
    state_t      state, state_d;
    logic        same, accept, fresh, good, wr, err_d, valid_d;
    logic [3:0]  nib;

    // Active-low g..a patterns; anything outside the table is flagged as bad.
    always_comb begin
        good = 1'b1;
        nib  = '0;
        unique case (s_seg[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: good = 1'b0;
        endcase
    end

    assign same   = (s_sel == p_sel) && (s_seg == p_seg);
    assign accept = same && (cnt == SETTLE_M1);
    // A re-accept of the digit just taken (e.g. after a short glitch) is dropped here.
    assign fresh  = accept && (s_sel != last_sel);

    always_comb begin
        state_d = state;
        exp_d   = exp_idx;
        dbuf_d  = dbuf;
        odata_d = odata;
        err_d   = 1'b0;
        valid_d = 1'b0;
        wr      = 1'b0;
        if (fresh) begin
            case (state)
                WAIT: begin
                    if (s_sel == 3'd0 && good) begin
                        wr      = 1'b1;
                        exp_d   = 3'd1;
                        state_d = COLLECT;
                    end else if (s_sel > 3'd5 || !good) begin
                        err_d = 1'b1;
                    end
                end
                COLLECT: begin
                    if (good && s_sel == exp_idx) begin
                        wr = 1'b1;
                        if (exp_idx == 3'd5) begin
                            odata_d = {dbuf[23:4], nib};
                            valid_d = 1'b1;
                            state_d = WAIT;
                        end else begin
                            exp_d = exp_idx + 3'd1;
                        end
                    end else if (good && s_sel == 3'd0) begin
                        err_d = 1'b1;
                        wr    = 1'b1;
                        exp_d = 3'd1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT;
                    end
                end
                default: state_d = WAIT;
            endcase
        end
        for (int unsigned i = 0; i < 6; i++) begin
            if (wr && s_sel == 3'(i)) dbuf_d[23 - 4*i -: 4] = nib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_m       <= '0;
            seg_m       <= '1;
            s_sel       <= '0;
            s_seg       <= '1;
            p_sel       <= '0;
            p_seg       <= '1;
            cnt         <= '0;
            state       <= WAIT;
            exp_idx     <= '0;
            last_sel    <= 3'd7;
            dbuf        <= '0;
            odata       <= '0;
            odata_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sel_m <= sel_in;
            seg_m <= seg_in;
            s_sel <= sel_m;
            s_seg <= seg_m;
            p_sel <= s_sel;
            p_seg <= s_seg;
            if (!same)
                cnt <= '0;
            else if (cnt < SETTLE_W)
                cnt <= cnt + 16'd1;
            if (fresh) last_sel <= s_sel;
            state       <= state_d;
            exp_idx     <= exp_d;
            dbuf        <= dbuf_d;
            odata       <= odata_d;
            odata_valid <= valid_d;
            frame_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_seven_tube_capture.sv
// Directed bench for seven_tube_capture: clean frames, glitch, bad pattern,
// out-of-order, invalid select and mid-frame reset, with SETTLE = 4.
module tb_seven_tube_capture;

    localparam int unsigned SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_in;
    logic [2:0]  sel_in;
    logic [23:0] odata;
    logic        odata_valid;
    logic        frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int valid_cnt, err_cnt, valid_k;
    bit both_seen = 1'b0;

    always #5 clk = ~clk;

    seven_tube_capture #(.SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .sel_in     (sel_in),
        .odata      (odata),
        .odata_valid(odata_valid),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Hand-written display codes with the decimal point off.
    function automatic logic [7:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 8'hC0;  4'h1: enc = 8'hF9;  4'h2: enc = 8'hA4;  4'h3: enc = 8'hB0;
            4'h4: enc = 8'h99;  4'h5: enc = 8'h92;  4'h6: enc = 8'h82;  4'h7: enc = 8'hF8;
            4'h8: enc = 8'h80;  4'h9: enc = 8'h90;  4'hA: enc = 8'h88;  4'hB: enc = 8'h83;
            4'hC: enc = 8'hC6;  4'hD: enc = 8'hA1;  4'hE: enc = 8'h86;  default: enc = 8'h8E;
        endcase
    endfunction

    task automatic clr();
        valid_cnt = 0;
        err_cnt   = 0;
        valid_k   = 0;
    endtask

    // Drive one dwell and tally output pulses; k counts posedges since the pin change.
    task automatic scan_digit(input logic [2:0] sel, input logic [7:0] seg, input int n);
        @(negedge clk);
        sel_in = sel;
        seg_in = seg;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (odata_valid === 1'b1) begin
                valid_cnt++;
                valid_k = k;
            end
            if (frame_err === 1'b1) err_cnt++;
            if (odata_valid === 1'b1 && frame_err === 1'b1) both_seen = 1'b1;
        end
    endtask

    task automatic scan_frame(input logic [23:0] d);
        for (int i = 0; i < 6; i++) scan_digit(3'(i), enc(d[23 - 4*i -: 4]), 20);
    endtask

    initial begin
        rst_n  = 1'b0;
        sel_in = 3'd5;
        seg_in = 8'hC0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        check("reset_odata", {8'h0, odata}, 32'h0);
        check("reset_valid", {31'h0, odata_valid}, 32'h0);
        check("reset_err", {31'h0, frame_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        scan_digit(3'd5, 8'hC0, 10);
        check("idle_err", err_cnt, 0);

        // Clean frame twice
        clr();
        scan_frame(24'h12AB9F);
        check("f1_odata", {8'h0, odata}, 32'h0012AB9F);
        check("f1_valid_cnt", valid_cnt, 1);
        check("f1_valid_lat", valid_k, 7);
        check("f1_err_cnt", err_cnt, 0);
        clr();
        scan_frame(24'h12AB9F);
        check("f2_valid_cnt", valid_cnt, 1);
        check("f2_err_cnt", err_cnt, 0);
        check("f2_odata", {8'h0, odata}, 32'h0012AB9F);

        // Short glitch to "8" during sel 2
        clr();
        scan_digit(3'd0, enc(4'h3), 20);
        scan_digit(3'd1, enc(4'hC), 20);
        scan_digit(3'd2, enc(4'h5), 10);
        scan_digit(3'd2, 8'h80, 3);
        scan_digit(3'd2, enc(4'h5), 7);
        scan_digit(3'd3, enc(4'hD), 20);
        scan_digit(3'd4, enc(4'h7), 20);
        scan_digit(3'd5, enc(4'hE), 20);
        check("glitch_odata", {8'h0, odata}, 32'h003C5D7E);
        check("glitch_valid_cnt", valid_cnt, 1);
        check("glitch_err_cnt", err_cnt, 0);

        // Blank pattern on sel 3
        clr();
        scan_digit(3'd0, enc(4'h4), 20);
        scan_digit(3'd1, enc(4'h5), 20);
        scan_digit(3'd2, enc(4'h6), 20);
        scan_digit(3'd3, 8'hFF, 20);
        scan_digit(3'd4, enc(4'h8), 20);
        scan_digit(3'd5, enc(4'h9), 20);
        check("bad_err_cnt", err_cnt, 1);
        check("bad_valid_cnt", valid_cnt, 0);
        check("bad_odata_kept", {8'h0, odata}, 32'h003C5D7E);
        clr();
        scan_frame(24'h000000);
        check("zero_odata", {8'h0, odata}, 32'h0);
        check("zero_valid_cnt", valid_cnt, 1);
        check("zero_err_cnt", err_cnt, 0);

        // Out-of-order restart at sel 0
        clr();
        scan_digit(3'd0, enc(4'hA), 20);
        scan_digit(3'd1, enc(4'hB), 20);
        scan_digit(3'd2, enc(4'hC), 20);
        scan_frame(24'hABCDEF);
        check("ooo_err_cnt", err_cnt, 1);
        check("ooo_valid_cnt", valid_cnt, 1);
        check("ooo_odata", {8'h0, odata}, 32'h00ABCDEF);

        // Invalid select 6 mid-frame, then digits ignored until sel 0
        clr();
        scan_digit(3'd0, enc(4'h1), 20);
        scan_digit(3'd1, enc(4'h1), 20);
        scan_digit(3'd6, enc(4'h1), 20);
        check("sel6_err_cnt", err_cnt, 1);
        clr();
        for (int i = 1; i < 6; i++) scan_digit(3'(i), enc(4'h2), 20);
        check("sel6_ignored_err", err_cnt, 0);
        check("sel6_ignored_valid", valid_cnt, 0);
        check("sel6_odata_kept", {8'h0, odata}, 32'h00ABCDEF);
        clr();
        scan_frame(24'h2468AC);
        check("after6_odata", {8'h0, odata}, 32'h002468AC);
        check("after6_valid_cnt", valid_cnt, 1);

        // Reset pulse during sel 4
        clr();
        for (int i = 0; i < 4; i++) scan_digit(3'(i), enc(4'(6 - i)), 20);
        scan_digit(3'd4, enc(4'h2), 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_odata", {8'h0, odata}, 32'h0);
        check("midrst_valid", {31'h0, odata_valid}, 32'h0);
        check("midrst_err", {31'h0, frame_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        scan_digit(3'd4, enc(4'h2), 15);
        scan_digit(3'd5, enc(4'h1), 20);
        check("postrst_err", err_cnt, 0);
        check("postrst_valid", valid_cnt, 0);
        check("postrst_odata", {8'h0, odata}, 32'h0);
        clr();
        scan_frame(24'h654321);
        check("rst_frame_odata", {8'h0, odata}, 32'h00654321);
        check("rst_frame_valid", valid_cnt, 1);
        check("rst_frame_err", err_cnt, 0);

        check("valid_err_overlap", {31'h0, both_seen}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
